decoder_scan: RTL and testbench
===============================

# decoder_scan

Parametrised, registered binary-to-one-hot decoder with a built-in scan sequencer. It converts a SEL_W-bit index into a 2^SEL_W-wide one-hot output. It also autonomously walks the active line up or down at a programmable rate, for row/column strobing and channel selection. It is the clocked, generalised successor to the team's combinational 2-to-4 decoder and sits between control logic and per-channel enables.

## Interface
- SEL_W, default 2: index width; output width is N = 2^SEL_W (legal 1..6).
- DIV_W, default 4: prescaler width; scan step period is div+1 cycles.

- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable; 0 freezes state and forces o to zero.
- mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 HOLD.
- sel  input  SEL_W  index loaded on load.
- load  input  1  load sel into the index register (any mode).
- div  input  DIV_W  scan prescale value; sampled every cycle.
- o  output  N  registered one-hot decode of idx; all zero when disabled.
- idx  output  SEL_W  current index register.
- wrap  output  1  one-cycle pulse when a scan step wraps.

## Operation
- State: idx (SEL_W), prescaler count pcnt (DIV_W), mode_q (last mode), o, wrap. All are registered.
- Reset (async assert, sync release): idx=0, pcnt=0, mode_q=DIRECT, o=0, wrap=0.
- en=0: idx, pcnt and mode_q hold. On the next edge o becomes 0 and wrap becomes 0. load is ignored.
- en=1, priority per edge:
  1. load=1: idx<=sel, pcnt<=0, wrap<=0.
  2. Mode change (mode != mode_q): pcnt<=0 and idx holds. The new mode takes effect from the next cycle.
  3. SCAN_UP/SCAN_DOWN with tick: idx<=idx±1 mod N.
  4. Otherwise idx holds.
- tick = (pcnt == div). On tick pcnt<=0; otherwise pcnt<=pcnt+1 in scan modes. pcnt holds in DIRECT and HOLD.
- wrap<=1 only on a scan step from N-1 to 0 (up) or from 0 to N-1 (down). It is 0 on every other edge.
- DIRECT and HOLD behave identically for idx. They are distinct codes so that a HOLD→SCAN transition restarts the prescaler.
- o<=onehot(next idx) when en=1. Bit k of o is set iff idx==k, so o and idx always agree after the same edge.
- If div changes mid-count and pcnt > new div, pcnt counts up, wraps at 2^DIV_W, and ticks on reaching div. No special handling is required.
- SEL_W=1: N=2. An up or down step always toggles idx, and wrap fires on each N-1→0 or 0→N-1 step.

## Timing
- Load latency: 1 cycle. sel is sampled at edge t, and idx/o are valid after edge t.
- Scan rate: one idx step every div+1 cycles. div=0 steps every cycle.
- First step after entering a scan mode, or after a load, occurs div+1 edges after the edge that cleared pcnt.
- wrap is coincident with the o/idx update that wrapped. Its width is exactly 1 cycle, including when div=0 and wraps are consecutive.
- Enable re-assert: o shows onehot(idx) on the first edge with en=1.
- Reset mid-scan: outputs go to reset values immediately, without waiting for a clock edge. The first post-reset edge behaves as if mode_q=DIRECT.

## Structure
- Shared package decoder_pkg holds:
  - Mode constants MODE_DIRECT=2'b00, MODE_SCAN_UP=2'b01, MODE_SCAN_DOWN=2'b10, MODE_HOLD=2'b11.
  - A function onehot(idx) returning N bits.
- One sub-module, tick_gen (parameter DIV_W). Ports: clk, rst, run, clr, div, tick. It owns pcnt. clr is driven by load or mode change, and run=en & scan mode.
- The top level owns idx, mode_q, o, wrap and the priority logic.

## Test plan
- Reset: assert rst mid-scan with SEL_W=2 → o=0000, idx=0, wrap=0 immediately. Release, en=1, mode=DIRECT → o=0001 on the next edge.
- Direct load: SEL_W=3, load sel=5 → o=00100000 and idx=5 one edge later. Loads of sel=0,7 → o=00000001, 10000000.
- Scan up with div=2, SEL_W=2, from idx=2: idx steps 2→3→0 on edges 3 and 6. wrap=1 only on the 3→0 edge and o=0001 there.
- Scan down with div=0, from idx=1: idx goes 0, 3, 2 on consecutive edges, and wrap=1 only on the 0→3 edge.
- Priority: in SCAN_UP, load sel=1 on the tick edge → idx=1 (no increment). The next step comes div+1 edges later.
- Enable gating: deassert en for 5 cycles during SCAN_UP, div=1 → o=0 and idx frozen. On re-enable, o=onehot(frozen idx) and stepping resumes with pcnt preserved.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the registered one-hot decoder with scan sequencer:
// mode encodings and the one-hot helper used by the top level.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_DIRECT    = 2'b00,
        MODE_SCAN_UP   = 2'b01,
        MODE_SCAN_DOWN = 2'b10,
        MODE_HOLD      = 2'b11
    } mode_e;

    localparam int unsigned MAX_SEL_W = 6;

    // Callers size the 64-bit result down to their own output width.
    function automatic logic [63:0] onehot(input logic [MAX_SEL_W-1:0] idx);
        return 64'(1) << idx;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Scan prescaler: counts pcnt up while running and flags a tick when it
// reaches div; a clear restarts the count from zero.
module tick_gen #(
    parameter int unsigned DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] pcnt_q;
    logic [DIV_W-1:0] pcnt_d;

    // Clear wins over counting; when div drops below pcnt the count wraps naturally.
    always_comb begin
        pcnt_d = pcnt_q;
        tick   = run && (pcnt_q == div);
        if (clr) begin
            pcnt_d = '0;
        end else if (run) begin
            pcnt_d = tick ? '0 : pcnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with an autonomous up/down scan
// sequencer; owns the index, last-mode register, one-hot output and wrap pulse.
module decoder_scan
    import decoder_pkg::*;
#(
    parameter int unsigned SEL_W = 2,
    parameter int unsigned DIV_W = 4,
    localparam int unsigned N    = 1 << SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [SEL_W-1:0] sel,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic [N-1:0]     o,
    output logic [SEL_W-1:0] idx,
    output logic             wrap
);

    localparam logic [SEL_W-1:0] IDX_MAX = SEL_W'(N - 1);

    mode_e            mode_in;
    mode_e            mode_q, mode_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [N-1:0]     o_q, o_d;
    logic             wrap_q, wrap_d;
    logic             mode_change;
    logic             scan_mode;
    logic             tick;
    logic             clr;
    logic             run;

    assign mode_in     = mode_e'(mode);
    assign mode_change = (mode_in != mode_q);
    assign scan_mode   = (mode_in == MODE_SCAN_UP) || (mode_in == MODE_SCAN_DOWN);
    assign clr         = en && (load || mode_change);
    assign run         = en && scan_mode;

    tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .run  (run),
        .clr  (clr),
        .div  (div),
        .tick (tick)
    );

    // Priority: load, then mode change (index holds), then a scan step on tick.
    always_comb begin
        idx_d  = idx_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        o_d    = '0;
        if (en) begin
            mode_d = mode_in;
            if (load) begin
                idx_d = sel;
            end else if (!mode_change && tick) begin
                if (mode_in == MODE_SCAN_UP) begin
                    idx_d  = idx_q + SEL_W'(1);
                    wrap_d = (idx_q == IDX_MAX);
                end else if (mode_in == MODE_SCAN_DOWN) begin
                    idx_d  = idx_q - SEL_W'(1);
                    wrap_d = (idx_q == '0);
                end
            end
            o_d = N'(onehot(MAX_SEL_W'(idx_d)));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q  <= '0;
            mode_q <= MODE_DIRECT;
            o_q    <= '0;
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            mode_q <= mode_d;
            o_q    <= o_d;
            wrap_q <= wrap_d;
        end
    end

    assign o    = o_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: a SEL_W=2 and a SEL_W=3 instance share
// control inputs; expected values are hand-computed per step.
module tb_decoder_scan;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [3:0] div;
    logic [1:0] sel2;
    logic [2:0] sel3;
    logic [3:0] o2;
    logic [1:0] idx2;
    logic       wrap2;
    logic [7:0] o3;
    logic [2:0] idx3;
    logic       wrap3;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    decoder_scan #(.SEL_W(2), .DIV_W(4)) dut2 (
        .clk (clk), .rst (rst), .en (en), .mode (mode), .sel (sel2),
        .load (load), .div (div), .o (o2), .idx (idx2), .wrap (wrap2)
    );

    decoder_scan #(.SEL_W(3), .DIV_W(4)) dut3 (
        .clk (clk), .rst (rst), .en (en), .mode (mode), .sel (sel3),
        .load (load), .div (div), .o (o3), .idx (idx3), .wrap (wrap3)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_idx[6]  = '{2, 2, 3, 3, 3, 0};
        int exp_wrap[6] = '{0, 0, 0, 0, 0, 1};

        rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; div = 4'd0;
        sel2 = 2'd0; sel3 = 3'd0;
        applyStimulus(2);

        // Reset mid-scan: run SCAN_UP at div=0, then assert rst between edges.
        rst = 1'b0; en = 1'b1; mode = 2'b01;
        applyStimulus(3);
        checkOutput("prescan_idx", 64'(idx2), 64'd2);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_o", 64'(o2), 64'h0);
        checkOutput("rst_idx", 64'(idx2), 64'd0);
        checkOutput("rst_wrap", 64'(wrap2), 64'd0);
        rst = 1'b0; mode = 2'b00;
        applyStimulus(1);
        checkOutput("post_rst_o2", 64'(o2), 64'h1);
        checkOutput("post_rst_o3", 64'(o3), 64'h01);

        // Direct loads on both widths.
        load = 1'b1; sel3 = 3'd5; sel2 = 2'd3;
        applyStimulus(1);
        checkOutput("load5_o3", 64'(o3), 64'h20);
        checkOutput("load5_idx3", 64'(idx3), 64'd5);
        checkOutput("load3_o2", 64'(o2), 64'h8);
        sel3 = 3'd0; sel2 = 2'd1;
        applyStimulus(1);
        checkOutput("load0_o3", 64'(o3), 64'h01);
        checkOutput("load1_o2", 64'(o2), 64'h2);
        sel3 = 3'd7; sel2 = 2'd2;
        applyStimulus(1);
        checkOutput("load7_o3", 64'(o3), 64'h80);
        checkOutput("load2_o2", 64'(o2), 64'h4);
        load = 1'b0;

        // Scan up, div=2, from idx=2; the mode-change edge clears the prescaler.
        mode = 2'b01; div = 4'd2;
        applyStimulus(1);
        checkOutput("up_modechg_idx", 64'(idx2), 64'd2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1);
            checkOutput($sformatf("up_idx_e%0d", i + 1), 64'(idx2), 64'(exp_idx[i]));
            checkOutput($sformatf("up_wrap_e%0d", i + 1), 64'(wrap2), 64'(exp_wrap[i]));
            if (i == 2) checkOutput("up_wrap3_e3", 64'(wrap3), 64'd1);
        end
        checkOutput("up_wrap_o", 64'(o2), 64'h1);

        // Scan down, div=0: load idx=1 while switching mode, then step each edge.
        mode = 2'b10; div = 4'd0; load = 1'b1; sel2 = 2'd1; sel3 = 3'd4;
        applyStimulus(1);
        load = 1'b0;
        checkOutput("dn_load_idx", 64'(idx2), 64'd1);
        applyStimulus(1);
        checkOutput("dn_idx_0", 64'(idx2), 64'd0);
        checkOutput("dn_wrap_0", 64'(wrap2), 64'd0);
        applyStimulus(1);
        checkOutput("dn_idx_3", 64'(idx2), 64'd3);
        checkOutput("dn_wrap_3", 64'(wrap2), 64'd1);
        checkOutput("dn_o_3", 64'(o2), 64'h8);
        applyStimulus(1);
        checkOutput("dn_idx_2", 64'(idx2), 64'd2);
        checkOutput("dn_wrap_2", 64'(wrap2), 64'd0);

        // Priority: load on the tick edge beats the increment.
        mode = 2'b01; div = 4'd2;
        applyStimulus(3);
        checkOutput("pri_pre_idx", 64'(idx2), 64'd2);
        load = 1'b1; sel2 = 2'd1;
        applyStimulus(1);
        load = 1'b0;
        checkOutput("pri_load_idx", 64'(idx2), 64'd1);
        applyStimulus(2);
        checkOutput("pri_hold_idx", 64'(idx2), 64'd1);
        applyStimulus(1);
        checkOutput("pri_step_idx", 64'(idx2), 64'd2);

        // Enable gating with div=1: prescaler sits at 1 when en drops.
        div = 4'd1;
        applyStimulus(1);
        checkOutput("gate_pre_idx", 64'(idx2), 64'd2);
        en = 1'b0; load = 1'b1; sel2 = 2'd0;
        applyStimulus(1);
        load = 1'b0;
        checkOutput("gate_o_first", 64'(o2), 64'h0);
        checkOutput("gate_idx_first", 64'(idx2), 64'd2);
        applyStimulus(4);
        checkOutput("gate_o_last", 64'(o2), 64'h0);
        checkOutput("gate_idx_last", 64'(idx2), 64'd2);
        checkOutput("gate_wrap", 64'(wrap2), 64'd0);
        en = 1'b1;
        applyStimulus(1);
        checkOutput("reen_idx", 64'(idx2), 64'd3);
        checkOutput("reen_o", 64'(o2), 64'h8);
        applyStimulus(1);
        checkOutput("reen_hold_idx", 64'(idx2), 64'd3);
        applyStimulus(1);
        checkOutput("reen_wrap_idx", 64'(idx2), 64'd0);
        checkOutput("reen_wrap", 64'(wrap2), 64'd1);
        checkOutput("reen_wrap_o", 64'(o2), 64'h1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
